alu_scheduler: RTL and testbench

- Shares the single 16-bit ALU between two requesters: port 0 is the execute stage, port 1 is the address/loop-counter unit.
- Provides round-robin arbitration with a valid/ready request handshake.
- Sequences each operation through the ALU's registered (1-cycle) stage, then returns the result and flags tagged with the requester id.
- Provides a lock so a requester can hold the ALU across ADD→ADC multi-word chains without the carry being corrupted by the other port.

---
 rtl/alu_scheduler_pkg.sv | 39 +++
 rtl/alu_rr_arbiter.sv | 97 +++++++++
 rtl/alu_scheduler.sv | 154 +++++++++++++++
 tb/tb_alu_scheduler.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_scheduler_pkg.sv
// Shared definitions for the ALU scheduler: instruction-set opcodes, FSM state
// encodings, response-flag bit positions and the flag packing helper.
package alu_scheduler_pkg;

  localparam int OP_W   = 5;
  localparam int FLAG_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 5'd0;
  localparam logic [OP_W-1:0] OP_ADC = 5'd1;
  localparam logic [OP_W-1:0] OP_SUB = 5'd2;
  localparam logic [OP_W-1:0] OP_SBB = 5'd3;
  localparam logic [OP_W-1:0] OP_CMP = 5'd4;
  localparam logic [OP_W-1:0] OP_INC = 5'd5;
  localparam logic [OP_W-1:0] OP_DEC = 5'd6;
  localparam logic [OP_W-1:0] OP_AND = 5'd7;
  localparam logic [OP_W-1:0] OP_OR  = 5'd8;
  localparam logic [OP_W-1:0] OP_XOR = 5'd9;
  localparam logic [OP_W-1:0] OP_NOT = 5'd10;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2
  } state_e;

  function automatic logic [FLAG_W-1:0] make_flags(input logic c, input logic s, input logic z);
    logic [FLAG_W-1:0] f;
    f         = {FLAG_W{1'b0}};
    f[FLAG_C] = c;
    f[FLAG_S] = s;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter.sv
// Two-way round-robin arbiter with a sticky lock for multi-word carry chains;
// a lock owner that stays silent too long in IDLE loses the lock.
module alu_rr_arbiter #(
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       idle_i,
  input  logic [1:0] req_valid,
  input  logic [1:0] req_lock,
  output logic [1:0] grant_o,
  output logic       lock_abort_o
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  logic             rr_q, rr_d;
  logic             locked_q, locked_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       owner_valid_s;
  logic       expire_s;
  logic       lock_eff_s;
  logic [1:0] grant_s;
  logic       take_s;
  logic       take_id_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= 1'b0;
      locked_q <= 1'b0;
      owner_q  <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      rr_q     <= rr_d;
      locked_q <= locked_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  // An expiring lock is already released for this cycle's arbitration, unless the owner shows up.
  always_comb begin
    owner_valid_s = req_valid[owner_q];
    expire_s      = locked_q && idle_i && !owner_valid_s && (cnt_q == CNT_W'(LOCK_TIMEOUT));
    lock_eff_s    = locked_q && !expire_s;
    grant_s       = 2'b00;
    if (!idle_i) begin
      grant_s = 2'b00;
    end else if (lock_eff_s) begin
      if (owner_q) begin
        grant_s = {req_valid[1], 1'b0};
      end else begin
        grant_s = {1'b0, req_valid[0]};
      end
    end else if (req_valid == 2'b11) begin
      if (rr_q) begin
        grant_s = 2'b10;
      end else begin
        grant_s = 2'b01;
      end
    end else begin
      grant_s = req_valid;
    end
    take_s    = |grant_s;
    take_id_s = grant_s[1];
  end

  always_comb begin
    rr_d     = rr_q;
    locked_d = locked_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    if (take_s) begin
      cnt_d = {CNT_W{1'b0}};
      if (req_lock[take_id_s]) begin
        locked_d = 1'b1;
        owner_d  = take_id_s;
      end else begin
        locked_d = 1'b0;
        rr_d     = ~take_id_s;
      end
    end else if (expire_s) begin
      locked_d = 1'b0;
      cnt_d    = {CNT_W{1'b0}};
    end else if (locked_q && idle_i && !owner_valid_s) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  assign grant_o      = grant_s;
  assign lock_abort_o = expire_s;

endmodule

// File: rtl/alu_scheduler.sv
// Shares one registered 16-bit ALU between the execute stage (id 0) and the
// address/loop-counter unit (id 1); each operation takes IDLE->ISSUE->CAPTURE.
module alu_scheduler
  import alu_scheduler_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_lock,
  input  logic [2*OP_W-1:0]   req_op,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic                rsp_valid,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_result,
  output logic [FLAG_W-1:0]   rsp_flags,
  output logic                lock_abort,
  output logic                alu_enable,
  output logic [OP_W-1:0]     alu_opcode,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                alu_zero,
  input  logic                alu_carry
);

  state_e state_q, state_d;

  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              id_q, id_d;
  logic              alu_enable_q, alu_enable_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;

  logic       idle_s;
  logic [1:0] grant_s;
  logic       accept_s;
  logic       acc_id_s;

  assign idle_s   = (state_q == ST_IDLE);
  assign accept_s = |grant_s;
  assign acc_id_s = grant_s[1];

  alu_rr_arbiter #(
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .idle_i      (idle_s),
    .req_valid   (req_valid),
    .req_lock    (req_lock),
    .grant_o     (grant_s),
    .lock_abort_o(lock_abort)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= {OP_W{1'b0}};
      a_q          <= {DATA_W{1'b0}};
      b_q          <= {DATA_W{1'b0}};
      id_q         <= 1'b0;
      alu_enable_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= {DATA_W{1'b0}};
      rsp_flags_q  <= {FLAG_W{1'b0}};
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      alu_enable_q <= alu_enable_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Operands are latched at accept and held steady until the next accept.
  always_comb begin
    op_d = op_q;
    a_d  = a_q;
    b_d  = b_q;
    id_d = id_q;
    if (accept_s) begin
      id_d = acc_id_s;
      if (acc_id_s) begin
        op_d = req_op[OP_W +: OP_W];
        a_d  = req_a[DATA_W +: DATA_W];
        b_d  = req_b[DATA_W +: DATA_W];
      end else begin
        op_d = req_op[OP_W-1:0];
        a_d  = req_a[DATA_W-1:0];
        b_d  = req_b[DATA_W-1:0];
      end
    end else begin
      id_d = id_q;
    end
  end

  // Sign comes from the result MSB; the ALU only supplies zero and carry.
  always_comb begin
    alu_enable_d = (state_d == ST_ISSUE);
    rsp_valid_d  = (state_q == ST_CAPTURE);
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    if (state_q == ST_CAPTURE) begin
      rsp_id_d     = id_q;
      rsp_result_d = alu_out;
      rsp_flags_d  = make_flags(alu_carry, alu_out[DATA_W-1], alu_zero);
    end else begin
      rsp_id_d = rsp_id_q;
    end
  end

  assign req_ready  = grant_s;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign alu_enable = alu_enable_q;
  assign alu_opcode = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Bench for alu_scheduler: behavioural registered ALU, table-driven single
// requests, contention/lock/timeout/reset sequences, scoreboard on responses.
module tb_alu_scheduler;
  import alu_scheduler_pkg::*;

  localparam int LT = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic v0, v1, lk0, lk1;
  logic [4:0] op0, op1;
  logic [15:0] a0, a1, b0, b1;
  logic [1:0] req_valid, req_lock, req_ready;
  logic [9:0] req_op;
  logic [31:0] req_a, req_b;
  logic rsp_valid, rsp_id, lock_abort, alu_enable;
  logic [15:0] rsp_result, alu_a, alu_b;
  logic [2:0] rsp_flags;
  logic [4:0] alu_opcode;
  logic [15:0] m_out = 16'd0;
  logic m_c = 1'b0, m_z = 1'b0;

  assign req_valid = {v1, v0};
  assign req_lock  = {lk1, lk0};
  assign req_op    = {op1, op0};
  assign req_a     = {a1, a0};
  assign req_b     = {b1, b0};

  alu_scheduler #(.DATA_W(16), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_lock(req_lock), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .lock_abort(lock_abort), .alu_enable(alu_enable),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(m_out), .alu_zero(m_z), .alu_carry(m_c)
  );

  // Behavioural ALU: result/zero/carry registers that hold when not written; never reset.
  function automatic logic [17:0] alu_f(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input logic zin, input logic [15:0] rin);
    logic [16:0] t;
    logic c, z, wr;
    logic [15:0] r;
    c = cin; z = zin; r = rin; wr = 1'b1; t = 17'd0;
    case (op)
      OP_ADD: begin t = {1'b0, a} + {1'b0, b};               c = t[16]; r = t[15:0]; end
      OP_ADC: begin t = {1'b0, a} + {1'b0, b} + {16'd0, cin}; c = t[16]; r = t[15:0]; end
      OP_SUB: begin t = {1'b0, a} - {1'b0, b};               c = t[16]; r = t[15:0]; end
      OP_SBB: begin t = {1'b0, a} - {1'b0, b} - {16'd0, cin}; c = t[16]; r = t[15:0]; end
      OP_CMP: begin t = {1'b0, a} - {1'b0, b}; c = t[16]; z = (t[15:0] == 16'd0); wr = 1'b0; end
      OP_INC: begin t = {1'b0, a} + 17'd1; c = t[16]; r = t[15:0]; end
      OP_DEC: begin t = {1'b0, a} - 17'd1; c = t[16]; r = t[15:0]; end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      default: wr = 1'b0;
    endcase
    if (wr) z = (r == 16'd0);
    return {c, z, r};
  endfunction

  always @(posedge clk) begin
    if (alu_enable) {m_c, m_z, m_out} <= alu_f(alu_opcode, alu_a, alu_b, m_c, m_z, m_out);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        id;
    logic [15:0] r;
    logic [2:0]  f;
    int          cyc;
  } exp_t;

  typedef struct {
    logic        id;
    logic [4:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        lock;
    logic [15:0] er;
    logic [2:0]  ef;
  } vec_t;

  exp_t sb[$];
  int acc_log[$];
  int last_acc_cyc = -10;
  logic [4:0] last_op;
  logic [15:0] last_a, last_b;
  int abort_cnt = 0, abort_cyc = -1;
  logic abort_ready1 = 1'b0;

  // Response scoreboard, issue-stage check and abort observer, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", 64'(rsp_id), 64'(e.id));
          chk("rsp_result", 64'(rsp_result), 64'(e.r));
          chk("rsp_flags", 64'(rsp_flags), 64'(e.f));
          chk("rsp_latency", 64'(cyc), 64'(e.cyc + 3));
        end
      end
      if (alu_enable) begin
        chk("alu_en_cycle", 64'(cyc), 64'(last_acc_cyc + 1));
        chk("alu_operands", 64'({alu_opcode, alu_a, alu_b}), 64'({last_op, last_a, last_b}));
      end
      if (req_valid == 2'b11) chk("ready_onehot", 64'($countones(req_ready) <= 1), 64'(1));
      if (lock_abort) begin
        abort_cnt++;
        abort_cyc    = cyc;
        abort_ready1 = req_ready[1];
      end
    end
  end

  task automatic req(input int id, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                     input logic lock, input logic [15:0] er, input logic [2:0] ef, input bit push);
    bit got;
    exp_t e;
    got = 1'b0;
    if (id == 0) begin v0 = 1'b1; op0 = op; a0 = a; b0 = b; lk0 = lock; end
    else         begin v1 = 1'b1; op1 = op; a1 = a; b1 = b; lk1 = lock; end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin
        got = 1'b1;
        acc_log.push_back(id);
        last_acc_cyc = cyc; last_op = op; last_a = a; last_b = b;
        if (push) begin
          e.id = id[0]; e.r = er; e.f = ef; e.cyc = cyc;
          sb.push_back(e);
        end
      end
    end
    chk("req_accepted", 64'(got), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic chk_log(input string nm, input int exp_ids[$]);
    chk({nm, "_count"}, 64'(acc_log.size()), 64'(exp_ids.size()));
    for (int i = 0; i < exp_ids.size() && i < acc_log.size(); i++)
      chk(nm, 64'(acc_log[i]), 64'(exp_ids[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t tbl[10];
  int lock_acc;

  initial begin
    v0 = 1'b0; v1 = 1'b0; lk0 = 1'b0; lk1 = 1'b0;
    op0 = 5'd0; op1 = 5'd0; a0 = 16'd0; a1 = 16'd0; b0 = 16'd0; b1 = 16'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, lock_abort,
                              alu_enable, alu_opcode, alu_a, alu_b}), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Sequential single requests; flags are {carry, sign, zero} and carry carries over.
    tbl[0] = '{1'b0, OP_ADD, 16'h0003, 16'h0004, 1'b0, 16'h0007, 3'b000};
    tbl[1] = '{1'b0, OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 3'b101};
    tbl[2] = '{1'b0, OP_XOR, 16'h8000, 16'h0000, 1'b0, 16'h8000, 3'b110};
    tbl[3] = '{1'b1, OP_ADC, 16'h0001, 16'h0001, 1'b0, 16'h0003, 3'b000};
    tbl[4] = '{1'b1, OP_SUB, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 3'b110};
    tbl[5] = '{1'b0, OP_AND, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 3'b101};
    tbl[6] = '{1'b1, 5'd31,  16'h1234, 16'h5678, 1'b0, 16'h0000, 3'b101};
    tbl[7] = '{1'b0, OP_NOT, 16'h00FF, 16'h0000, 1'b0, 16'hFF00, 3'b110};
    tbl[8] = '{1'b0, OP_INC, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 3'b010};
    tbl[9] = '{1'b1, OP_SBB, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'b001};
    for (int i = 0; i < 10; i++) begin
      req(int'(tbl[i].id), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lock, tbl[i].er, tbl[i].ef, 1'b1);
      v0 = 1'b0; v1 = 1'b0;
    end
    repeat (4) @(posedge clk); #1;

    // Contention: both valid continuously, grants must alternate starting with 0.
    acc_log.delete();
    fork
      begin
        req(0, OP_SUB, 16'h0005, 16'h0005, 1'b0, 16'h0000, 3'b001, 1'b1);
        req(0, OP_SUB, 16'h0005, 16'h0005, 1'b0, 16'h0000, 3'b001, 1'b1);
        v0 = 1'b0;
      end
      begin
        req(1, OP_INC, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 3'b101, 1'b1);
        req(1, OP_INC, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 3'b101, 1'b1);
        v1 = 1'b0;
      end
    join
    chk_log("rr_order", '{0, 1, 0, 1});
    repeat (4) @(posedge clk); #1;

    // Lock chain: requester 1 holds the ALU across ADD/ADC while requester 0 waits.
    acc_log.delete();
    fork
      begin
        req(1, OP_ADD, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 3'b101, 1'b1);
        req(1, OP_ADC, 16'h0000, 16'h0000, 1'b0, 16'h0001, 3'b000, 1'b1);
        v1 = 1'b0;
      end
      begin
        @(posedge clk); #1;
        req(0, OP_XOR, 16'h8000, 16'h0000, 1'b0, 16'h8000, 3'b010, 1'b1);
        v0 = 1'b0;
      end
    join
    chk_log("lock_order", '{1, 1, 0});
    repeat (4) @(posedge clk); #1;

    // Timeout: requester 0 locks then goes silent; requester 1 gets in on the abort cycle.
    acc_log.delete();
    abort_cnt = 0;
    req(0, OP_ADD, 16'h0001, 16'h0001, 1'b1, 16'h0002, 3'b000, 1'b1);
    lock_acc = last_acc_cyc;
    v0 = 1'b0;
    req(1, OP_OR, 16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 3'b000, 1'b1);
    v1 = 1'b0;
    chk_log("timeout_order", '{0, 1});
    chk("abort_count", 64'(abort_cnt), 64'(1));
    chk("abort_same_cycle_grant", 64'(abort_cyc), 64'(last_acc_cyc));
    chk("abort_ready1", 64'(abort_ready1), 64'(1));
    chk("abort_delay_window", 64'((abort_cyc - lock_acc >= LT + 2) && (abort_cyc - lock_acc <= LT + 4)), 64'(1));
    repeat (5) @(posedge clk); #1;
    chk("abort_count_after", 64'(abort_cnt), 64'(1));

    // Asynchronous reset during ISSUE drops the operation without a response.
    chk("sb_empty_before_reset", 64'(sb.size()), 64'(0));
    req(0, OP_ADD, 16'h0003, 16'h0004, 1'b0, 16'h0007, 3'b000, 1'b0);
    v0 = 1'b0;
    chk("issue_enable", 64'(alu_enable), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("reset_mid_outputs", 64'({req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, lock_abort,
                                  alu_enable, alu_opcode, alu_a, alu_b}), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk); #1;
    req(0, OP_ADD, 16'h0003, 16'h0004, 1'b0, 16'h0007, 3'b000, 1'b1);
    v0 = 1'b0;

    repeat (6) @(posedge clk); #1;
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
